comparator_array: RTL and testbench

COMPARATOR_ARRAY -- requirements
Module: comparator_array

---
 rtl/comparator_array_pkg.sv | 17 +
 rtl/comparator_array_if.sv | 27 ++
 rtl/comparator_array_channel.sv | 79 +++++++
 rtl/comparator_array.sv | 68 ++++++
 tb/tb_comparator_array.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/comparator_array_pkg.sv
// comparator_array_pkg: shared FSM state encoding and default parameter values
package comparator_array_pkg;

    typedef enum logic [1:0] {
        ST_HIGH,
        ST_FALL_PEND,
        ST_LOW,
        ST_RISE_PEND
    } state_t;

    localparam int DEF_WIDTH    = 10;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_HYST     = 0;
    localparam int DEF_P_MAX    = 512;
    localparam int DEF_CNT_W    = 4;

endpackage

// File: rtl/comparator_array_if.sv
// comparator_array_if: per-channel enables, settle count, packed p/n codes and decisions
interface comparator_array_if
    import comparator_array_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int CNT_W    = DEF_CNT_W
);

    logic [CHANNELS-1:0]       en;
    logic [CNT_W-1:0]          settle_cycles;
    logic [CHANNELS*WIDTH-1:0] p_voltage_real;
    logic [CHANNELS*WIDTH-1:0] n_voltage_real;
    logic [CHANNELS-1:0]       out_digital;
    logic [CHANNELS-1:0]       out_valid;

    modport master (
        output en, settle_cycles, p_voltage_real, n_voltage_real,
        input  out_digital, out_valid
    );

    modport slave (
        input  en, settle_cycles, p_voltage_real, n_voltage_real,
        output out_digital, out_valid
    );

endinterface

// File: rtl/comparator_array_channel.sv
// comparator_channel: one comparator with hysteresis, P_MAX ceiling and settle-count debounce
module comparator_channel
    import comparator_array_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int HYST  = DEF_HYST,
    parameter int P_MAX = DEF_P_MAX,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic             en,
    input  logic [CNT_W-1:0] settle_cycles,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] n,
    output logic             out_digital,
    output logic             out_valid
);

    localparam int             PM_MAX = (2 ** (WIDTH + 1)) - 1;
    localparam int             PM     = (P_MAX > PM_MAX) ? PM_MAX : P_MAX;
    localparam logic [WIDTH:0] H      = (WIDTH + 1)'(HYST);
    localparam logic [WIDTH:0] PMX    = (WIDTH + 1)'(PM);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             commit;
    logic [WIDTH:0]   pe, ne;
    logic             fall_cond, rise_cond;
    logic             hi, pend, cond, done;

    // One extra bit keeps p+HYST and n+HYST from wrapping
    assign pe        = {1'b0, p};
    assign ne        = {1'b0, n};
    assign fall_cond = (p != '0) && (pe + H <= ne);
    assign rise_cond = (pe > ne + H) && (pe <= PMX);
    assign hi        = (state == ST_HIGH) || (state == ST_FALL_PEND);
    assign pend      = (state == ST_FALL_PEND) || (state == ST_RISE_PEND);
    assign cond      = hi ? fall_cond : rise_cond;
    // cnt is zero outside pend states, so this also covers settle_cycles==0 from HIGH/LOW
    assign done      = ({1'b0, cnt} + (CNT_W + 1)'(1)) > {1'b0, settle_cycles};
    assign out_digital = hi;

    // Next state: abort on lost condition, commit once the streak exceeds settle_cycles, else count
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        commit  = 1'b0;
        if (strobe && en) begin
            if (!cond) begin
                state_d = hi ? ST_HIGH : ST_LOW;
                cnt_d   = '0;
            end else if (done) begin
                state_d = hi ? ST_LOW : ST_HIGH;
                cnt_d   = '0;
                commit  = 1'b1;
            end else begin
                state_d = hi ? ST_FALL_PEND : ST_RISE_PEND;
                cnt_d   = (&cnt) ? cnt : cnt + CNT_W'(1);
            end
        end
        if (pend && !(strobe && en)) state_d = state;
    end

    // State, settle counter and the registered commit pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_HIGH;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            out_valid <= commit;
        end
    end

endmodule

// File: rtl/comparator_array.sv
// comparator_array: strobe-driven array of debounced comparators; SYS_CLK_SYNC_EN adds a 2-flop sys_clk synchronizer
module comparator_array
    import comparator_array_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int HYST     = DEF_HYST,
    parameter int P_MAX    = DEF_P_MAX,
    parameter int CNT_W    = DEF_CNT_W
) (
    input logic                clk,
    input logic                reset,
    input logic                sys_clk,
    comparator_array_if.slave  bus
);

    if (WIDTH < 2)                 begin : g_bad_width $error("WIDTH must be at least 2"); end
    if (CHANNELS < 1)              begin : g_bad_ch    $error("CHANNELS must be at least 1"); end
    if (HYST < 0 || HYST >= (1 << WIDTH)) begin : g_bad_hyst $error("HYST must be in [0, 2^WIDTH)"); end
    if (CNT_W < 1)                 begin : g_bad_cnt   $error("CNT_W must be at least 1"); end

    logic                sys_in, prev_sys_clk, strobe;
    logic [CHANNELS-1:0] od, ov;

`ifdef SYS_CLK_SYNC_EN
    logic [1:0] sys_sync;

    // Two-flop synchronizer for the asynchronous evaluation strobe source
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sys_sync <= '0;
        else        sys_sync <= {sys_sync[0], sys_clk};
    end

    assign sys_in = sys_sync[1];
`else
    assign sys_in = sys_clk;
`endif

    // Previous sys level for rising-edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_sys_clk <= 1'b0;
        else        prev_sys_clk <= sys_in;
    end

    assign strobe          = sys_in & ~prev_sys_clk;
    assign bus.out_digital = od;
    assign bus.out_valid   = ov;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        comparator_channel #(
            .WIDTH (WIDTH),
            .HYST  (HYST),
            .P_MAX (P_MAX),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk           (clk),
            .reset         (reset),
            .strobe        (strobe),
            .en            (bus.en[g]),
            .settle_cycles (bus.settle_cycles),
            .p             (bus.p_voltage_real[g*WIDTH +: WIDTH]),
            .n             (bus.n_voltage_real[g*WIDTH +: WIDTH]),
            .out_digital   (od[g]),
            .out_valid     (ov[g])
        );
    end

endmodule

// File: tb/tb_comparator_array.sv
// tb_comparator_array: directed scenarios plus random stimulus against a streak-counting reference model
module tb_comparator_array;

    localparam int W    = 10;
    localparam int CH   = 4;
    localparam int HYST = 8;
    localparam int PMAX = 512;
    localparam int CW   = 4;
`ifdef SYS_CLK_SYNC_EN
    localparam int LAT  = 2;
`else
    localparam int LAT  = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sys_clk = 1'b0;

    comparator_array_if #(.WIDTH(W), .CHANNELS(CH), .CNT_W(CW)) bus ();

    comparator_array #(
        .WIDTH(W), .CHANNELS(CH), .HYST(HYST), .P_MAX(PMAX), .CNT_W(CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sys_clk (sys_clk),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [CH-1:0]   mout = '1;
    int              run [CH];
    logic [3:0]      sh = '0;
    logic [2*CH-1:0] q [$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: count consecutive qualifying strobes; the decision flips when the streak exceeds settle_cycles
    task automatic model_eval();
        logic [CH-1:0] m;
        int p, n;
        bit st, want;
        sh = {sh[2:0], sys_clk};
        st = (LAT == 0) ? (sh[0] & ~sh[1]) : (sh[2] & ~sh[3]);
        m = '0;
        if (st) begin
            for (int i = 0; i < CH; i++) begin
                if (bus.en[i]) begin
                    p = int'(bus.p_voltage_real[i*W +: W]);
                    n = int'(bus.n_voltage_real[i*W +: W]);
                    want = mout[i] ? (p > 0 && p + HYST <= n) : (p > n + HYST && p <= PMAX);
                    if (!want) run[i] = 0;
                    else begin
                        run[i]++;
                        if (run[i] > int'(bus.settle_cycles)) begin
                            run[i] = 0;
                            m[i] = 1'b1;
                        end
                    end
                end
            end
        end
        if (m != '0) begin
            mout ^= m;
            q.push_back({m, mout});
        end
    endtask

    task automatic tick(input logic s);
        sys_clk = s;
        model_eval();
        @(negedge clk);
    endtask

    task automatic strobe();
        tick(1'b1);
        repeat (3) tick(1'b0);
    endtask

    task automatic setpn(input int ch, input int p, input int n);
        bus.p_voltage_real[ch*W +: W] = W'(p);
        bus.n_voltage_real[ch*W +: W] = W'(n);
    endtask

    // Monitor: every cycle compare decisions, and pair each out_valid pulse with a queued expectation
    always @(posedge clk) begin
        logic [2*CH-1:0] e;
        #1;
        chk("out_digital", 32'(bus.out_digital), 32'(mout));
        if (bus.out_valid != '0 || q.size() != 0) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got %0h expected 0 at %0t", bus.out_valid, $time);
            end else begin
                e = q.pop_front();
                chk("pulse_mask", 32'(bus.out_valid), 32'(e[2*CH-1:CH]));
                chk("pulse_out", 32'(bus.out_digital), 32'(e[CH-1:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        for (int i = 0; i < CH; i++) run[i] = 0;
        bus.en = '1;
        bus.settle_cycles = '0;
        for (int i = 0; i < CH; i++) setpn(i, 100, 100);
        #1;
        chk("reset_out_digital", 32'(bus.out_digital), 32'hf);
        chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0);

        // Scenario 1: direct fall with settle 0
        setpn(0, 100, 200);
        strobe();
        chk("s1_fall", 32'(bus.out_digital[0]), 32'h0);

        // Scenario 2: rise, then P_MAX ceiling blocks a rise
        setpn(0, 300, 200);
        strobe();
        chk("s2_rise", 32'(bus.out_digital[0]), 32'h1);
        setpn(0, 100, 200);
        strobe();
        setpn(0, 600, 200);
        strobe();
        chk("s2_pmax_block", 32'(bus.out_digital[0]), 32'h0);
        setpn(0, 300, 200);
        strobe();

        // Scenario 3: abort after 2 strobes, then commit on the 4th
        bus.settle_cycles = 4'd3;
        setpn(0, 100, 200);
        repeat (2) strobe();
        setpn(0, 200, 200);
        strobe();
        chk("s3_abort", 32'(bus.out_digital[0]), 32'h1);
        setpn(0, 100, 200);
        repeat (3) strobe();
        chk("s3_pending", 32'(bus.out_digital[0]), 32'h1);
        strobe();
        chk("s3_commit", 32'(bus.out_digital[0]), 32'h0);
        bus.settle_cycles = '0;
        setpn(0, 300, 200);
        strobe();

        // Scenario 4: hysteresis boundary
        setpn(0, 195, 200);
        strobe();
        chk("s4_no_fall", 32'(bus.out_digital[0]), 32'h1);
        setpn(0, 192, 200);
        strobe();
        chk("s4_fall", 32'(bus.out_digital[0]), 32'h0);
        setpn(0, 300, 200);
        strobe();

        // Scenario 5: async reset mid-pend, then p=0 never falls
        bus.settle_cycles = 4'd3;
        setpn(0, 100, 200);
        repeat (2) strobe();
        #2 reset = 1'b0;
        #1;
        chk("s5_rst_out", 32'(bus.out_digital), 32'hf);
        chk("s5_rst_valid", 32'(bus.out_valid), 32'h0);
        for (int i = 0; i < CH; i++) run[i] = 0;
        mout = '1;
        sh = '0;
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        bus.settle_cycles = '0;
        setpn(0, 0, 5);
        repeat (2) strobe();
        chk("s5_p_zero", 32'(bus.out_digital[0]), 32'h1);

        // Scenario 6: all channels commit on one strobe, latency depends on synchronizer
        for (int i = 0; i < CH; i++) setpn(i, 100, 200);
        tick(1'b1);
        found = -1;
        for (int c = 0; c < 5; c++) begin
            if (found < 0 && bus.out_valid == '1) found = c;
            tick(1'b0);
        end
        chk("s6_latency", 32'(found), 32'(LAT));
        chk("s6_all_low", 32'(bus.out_digital), 32'h0);

        // Random phase
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < CH; i++) begin
                int n, p;
                bus.en[i] = ($urandom_range(0, 9) != 0);
                n = $urandom_range(0, 1023);
                p = n + $urandom_range(0, 40) - 20;
                case ($urandom_range(0, 7))
                    0: p = 0;
                    1: begin n = $urandom_range(0, 100); p = $urandom_range(480, 700); end
                    default: ;
                endcase
                if (p < 0) p = 0;
                if (p > 1023) p = 1023;
                setpn(i, p, n);
            end
            if ($urandom_range(0, 7) == 0)
                bus.settle_cycles = ($urandom_range(0, 15) == 0) ? 4'd15 : CW'($urandom_range(0, 3));
            tick(1'($urandom_range(0, 1)));
        end
        repeat (4) tick(1'b0);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
